// File: rtl/seg7_pkg.sv
// Shared types, glyph table and helpers for the multi-digit seven-segment controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

    // Per-digit attribute word; bit layout matches i_wr_data[6:0].
    typedef struct packed {
        logic       blink;
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } digit_t;

    // Active-high glyphs, bit order {dp,g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F.
    localparam logic [7:0] C_SEG7_HEX [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // A digit comes out of reset blanked, with every other attribute cleared.
    localparam digit_t C_DIG_BLANK = '{blink: 1'b0, blank: 1'b1, dp: 1'b0, hex: 4'h0};

    // Digit-index width; a single-digit display still gets a 1-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_multi_ctrl_if.sv
// Digit-register write bus between the register bridge (master) and the display controller (slave).
// Latency: ack/err return one cycle after the strobe.
// Backpressure: none; a write may be issued every cycle.
interface seg7_multi_ctrl_if #(
    parameter int G_NB_DIGITS = 8
);
    localparam int AW = seg7_pkg::addr_width(G_NB_DIGITS);

    logic          i_wr_en;    // one-cycle write strobe
    logic [AW-1:0] i_wr_addr;  // digit index
    logic [7:0]    i_wr_data;  // [3:0] hex, [4] dp, [5] blank, [6] blink, [7] reserved
    logic          o_wr_ack;   // pulse: write landed
    logic          o_wr_err;   // pulse: address out of range, write dropped

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data,
        input  o_wr_ack, o_wr_err
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data,
        output o_wr_ack, o_wr_err
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Turns one digit's attributes plus the blink phase into an active-high segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  digit_t     i_dig,          // digit attributes
    input  logic       i_blink_phase,  // 1 = "dark" half of the blink period
    output logic [7:0] o_seg           // {dp,g,f,e,d,c,b,a}, active-high
);

    logic [7:0] glyph;

    always_comb begin
        glyph = C_SEG7_HEX[i_dig.hex];
        o_seg = {i_dig.dp, glyph[6:0]};
        // Blanking wins over everything, including the decimal point.
        if (i_dig.blank || (i_dig.blink && i_blink_phase)) begin
            o_seg = 8'h00;
        end
    end

endmodule

// File: rtl/seg7_multi_ctrl.sv
// N-digit seven-segment controller: per-digit attribute regs, static bus or scanned segment/anode outputs.
// Latency: write strobe -> ack 1 edge, -> display output 2 edges; mode change -> new mode valid 2 edges.
// Backpressure: none; writes accepted every cycle, out-of-range writes flagged via o_wr_err.
// Ports: clk, rst_n (sync, active-low), wr_if (write bus slave), i_mode (0 static / 1 mux),
//        o_seg (8 bits per digit), o_mux_seg / o_mux_an (scanned segment bus and one-hot anodes).
module seg7_multi_ctrl
    import seg7_pkg::*;
#(
    parameter int G_NB_DIGITS  = 8,
    parameter int G_SCAN_DIV   = 1000,
    parameter int G_BLINK_DIV  = 25000000,
    parameter int G_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seg7_multi_ctrl_if.slave         wr_if,
    input  logic                     i_mode,
    output logic [8*G_NB_DIGITS-1:0] o_seg,
    output logic [7:0]               o_mux_seg,
    output logic [G_NB_DIGITS-1:0]   o_mux_an
);

    localparam int AW  = addr_width(G_NB_DIGITS);
    localparam int SCW = $clog2(G_SCAN_DIV);
    localparam int BLW = $clog2(G_BLINK_DIV);

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(G_SCAN_DIV - 1);
    localparam logic [BLW-1:0] BLINK_LAST = BLW'(G_BLINK_DIV - 1);
    localparam logic [AW-1:0]  IDX_LAST   = AW'(G_NB_DIGITS - 1);

    // Polarity mask: XOR with this turns active-high into pin polarity; also the "off" value.
    localparam logic                   POL    = (G_ACTIVE_LOW != 0);
    localparam logic [7:0]             OFF8   = {8{POL}};
    localparam logic [G_NB_DIGITS-1:0] OFF_AN = {G_NB_DIGITS{POL}};

    digit_t                   dig_q [G_NB_DIGITS];
    digit_t                   dig_d [G_NB_DIGITS];
    logic                     wr_ack_q, wr_ack_d;
    logic                     wr_err_q, wr_err_d;
    logic                     mode_q, mode_d;
    logic [SCW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [AW-1:0]            scan_idx_q, scan_idx_d;
    logic [BLW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                     blink_ph_q, blink_ph_d;
    logic [8*G_NB_DIGITS-1:0] seg_q, seg_d;
    logic [7:0]               mux_seg_q, mux_seg_d;
    logic [G_NB_DIGITS-1:0]   mux_an_q, mux_an_d;

    logic [7:0]               dec_seg [G_NB_DIGITS];
    logic [7:0]               mux_dec;
    logic [G_NB_DIGITS-1:0]   an_hot;
    logic                     addr_ok;
    logic                     mode_chg;
    logic                     mux_lit;
    logic                     wr_rsvd_unused;

    assign wr_rsvd_unused = wr_if.i_wr_data[7];
    assign addr_ok        = (int'(wr_if.i_wr_addr) < G_NB_DIGITS);
    assign mode_chg       = (i_mode != mode_q);

    // One decoder per digit for the static bus, one more for the scanned digit.
    for (genvar g = 0; g < G_NB_DIGITS; g++) begin : g_dec
        seg7_hex_decoder u_dec (
            .i_dig         (dig_q[g]),
            .i_blink_phase (blink_ph_q),
            .o_seg         (dec_seg[g])
        );
    end

    seg7_hex_decoder u_mux_dec (
        .i_dig         (dig_q[scan_idx_q]),
        .i_blink_phase (blink_ph_q),
        .o_seg         (mux_dec)
    );

    // Digit registers and write response.
    always_comb begin
        for (int k = 0; k < G_NB_DIGITS; k++) begin
            dig_d[k] = dig_q[k];
        end
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        if (wr_if.i_wr_en) begin
            if (addr_ok) begin
                dig_d[wr_if.i_wr_addr] = digit_t'(wr_if.i_wr_data[6:0]);
                wr_ack_d               = 1'b1;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Blink timebase runs regardless of mode so blink rate never jumps on a mode change.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    // Scan position: parked at digit 0 in static mode and restarted on any mode change.
    always_comb begin
        mode_d     = i_mode;
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (!mode_q || mode_chg) begin
            scan_cnt_d = '0;
            scan_idx_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
    end

    // Output registers. The last count of each digit slot is rendered dark, so the
    // registered outputs are all-off on exactly the cycle the index advances.
    always_comb begin
        an_hot             = '0;
        an_hot[scan_idx_q] = 1'b1;
        mux_lit            = mode_q && (scan_cnt_q != SCAN_LAST);

        for (int k = 0; k < G_NB_DIGITS; k++) begin
            seg_d[8*k +: 8] = mode_q ? OFF8 : (dec_seg[k] ^ OFF8);
        end
        mux_seg_d = mux_lit ? (mux_dec ^ OFF8) : OFF8;
        mux_an_d  = mux_lit ? (an_hot ^ OFF_AN) : OFF_AN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < G_NB_DIGITS; k++) begin
                dig_q[k] <= C_DIG_BLANK;
            end
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            mode_q      <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            seg_q       <= {(8*G_NB_DIGITS){POL}};
            mux_seg_q   <= OFF8;
            mux_an_q    <= OFF_AN;
        end else begin
            for (int k = 0; k < G_NB_DIGITS; k++) begin
                dig_q[k] <= dig_d[k];
            end
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            mode_q      <= mode_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            seg_q       <= seg_d;
            mux_seg_q   <= mux_seg_d;
            mux_an_q    <= mux_an_d;
        end
    end

    assign wr_if.o_wr_ack = wr_ack_q;
    assign wr_if.o_wr_err = wr_err_q;
    assign o_seg          = seg_q;
    assign o_mux_seg      = mux_seg_q;
    assign o_mux_an       = mux_an_q;

endmodule

// File: tb/tb_seg7_multi_ctrl.sv
// Directed bench for seg7_multi_ctrl: 4-digit main instance plus a 3-digit instance for out-of-range writes.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_multi_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        i_mode;
    logic [31:0] o_seg;
    logic [7:0]  o_mux_seg;
    logic [3:0]  o_mux_an;

    logic        i_mode2;
    logic [23:0] o_seg2;
    logic [7:0]  o_mux_seg2;
    logic [2:0]  o_mux_an2;

    seg7_multi_ctrl_if #(.G_NB_DIGITS(4)) wr_if ();
    seg7_multi_ctrl_if #(.G_NB_DIGITS(3)) wr_if2 ();

    seg7_multi_ctrl #(
        .G_NB_DIGITS(4), .G_SCAN_DIV(4), .G_BLINK_DIV(8), .G_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_if(wr_if.slave), .i_mode(i_mode),
        .o_seg(o_seg), .o_mux_seg(o_mux_seg), .o_mux_an(o_mux_an)
    );

    seg7_multi_ctrl #(
        .G_NB_DIGITS(3), .G_SCAN_DIV(4), .G_BLINK_DIV(8), .G_ACTIVE_LOW(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_if(wr_if2.slave), .i_mode(i_mode2),
        .o_seg(o_seg2), .o_mux_seg(o_mux_seg2), .o_mux_an(o_mux_an2)
    );

    int errors = 0;
    int checks = 0;
    int ecnt;

    // Edges since reset release; the blink phase follows directly from this count.
    always @(posedge clk) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [7:0] wr_dat_t [4];
    logic [3:0] an_exp   [4];
    logic [7:0] seg_exp  [4];
    logic [7:0] blink_exp;

    initial begin
        wr_dat_t = '{8'h01, 8'h02, 8'h03, 8'h14};
        an_exp   = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_exp  = '{8'hF9, 8'hA4, 8'hB0, 8'h19};

        rst_n = 1'b0;
        i_mode = 1'b0;
        i_mode2 = 1'b0;
        wr_if.i_wr_en = 1'b0;  wr_if.i_wr_addr = '0;  wr_if.i_wr_data = '0;
        wr_if2.i_wr_en = 1'b0; wr_if2.i_wr_addr = '0; wr_if2.i_wr_data = '0;

        // Reset state.
        repeat (3) step();
        chk("rst_seg",     o_seg,     32'hFFFF_FFFF);
        chk("rst_mux_an",  {28'h0, o_mux_an}, 32'hF);
        chk("rst_mux_seg", {24'h0, o_mux_seg}, 32'hFF);
        chk("rst_ack_err", {30'h0, wr_if.o_wr_ack, wr_if.o_wr_err}, 32'h0);

        // Static write: digit 2 = 5, two-edge latency to the pins.
        rst_n = 1'b1;
        wr_if.i_wr_en = 1'b1; wr_if.i_wr_addr = 2'd2; wr_if.i_wr_data = 8'h05;
        step();
        chk("wr_ack",      {30'h0, wr_if.o_wr_ack, wr_if.o_wr_err}, 32'h2);
        chk("wr_lat1_seg", o_seg, 32'hFFFF_FFFF);
        wr_if.i_wr_en = 1'b0;
        step();
        chk("wr_lat2_seg", o_seg, 32'hFF92_FFFF);
        chk("wr_ack_pulse", {31'h0, wr_if.o_wr_ack}, 32'h0);

        // Out-of-range write on the 3-digit instance, then a valid one.
        wr_if2.i_wr_en = 1'b1; wr_if2.i_wr_addr = 2'd3; wr_if2.i_wr_data = 8'h01;
        step();
        chk("err_pulse", {30'h0, wr_if2.o_wr_ack, wr_if2.o_wr_err}, 32'h1);
        wr_if2.i_wr_en = 1'b0;
        step();
        chk("err_seg_unchg", {8'h0, o_seg2}, 32'h00FF_FFFF);
        chk("err_clear", {30'h0, wr_if2.o_wr_ack, wr_if2.o_wr_err}, 32'h0);
        wr_if2.i_wr_en = 1'b1; wr_if2.i_wr_addr = 2'd2; wr_if2.i_wr_data = 8'h0A;
        step();
        chk("n3_ack", {30'h0, wr_if2.o_wr_ack, wr_if2.o_wr_err}, 32'h2);
        wr_if2.i_wr_en = 1'b0;
        step();
        chk("n3_seg", {8'h0, o_seg2}, 32'h0088_FFFF);

        // Back-to-back writes: digits 0..3 = 1,2,3,4 with dp on digit 3.
        for (int i = 0; i < 4; i++) begin
            wr_if.i_wr_en = 1'b1; wr_if.i_wr_addr = 2'(i); wr_if.i_wr_data = wr_dat_t[i];
            step();
            chk("b2b_ack", {31'h0, wr_if.o_wr_ack}, 32'h1);
        end
        wr_if.i_wr_en = 1'b0;
        step();
        chk("b2b_seg", o_seg, 32'h19B0_A4F9);

        // Mux mode: three lit cycles per digit then a one-cycle dark gap, two full rounds.
        i_mode = 1'b1;
        step();
        step();
        chk("mux_seg_off", o_seg, 32'hFFFF_FFFF);
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 3; c++) begin
                    chk("mux_lit", {20'h0, o_mux_an, o_mux_seg}, {20'h0, an_exp[d], seg_exp[d]});
                    step();
                end
                chk("mux_gap", {20'h0, o_mux_an, o_mux_seg}, 32'h0000_0FFF);
                step();
            end
        end

        // Switch to static while digit 2 is lit, then back: scan restarts at digit 0.
        repeat (9) step();
        chk("mux_idx2", {20'h0, o_mux_an, o_mux_seg}, 32'h0000_0BB0);
        i_mode = 1'b0;
        step();
        step();
        chk("sw_static_seg", o_seg, 32'h19B0_A4F9);
        chk("sw_static_mux", {20'h0, o_mux_an, o_mux_seg}, 32'h0000_0FFF);
        i_mode = 1'b1;
        step();
        step();
        chk("sw_mux_restart", {20'h0, o_mux_an, o_mux_seg}, 32'h0000_0EF9);

        // Blink: digit 0 = hex 8 with blink, static mode.
        i_mode = 1'b0;
        wr_if.i_wr_en = 1'b1; wr_if.i_wr_addr = 2'd0; wr_if.i_wr_data = 8'h48;
        step();
        chk("blink_ack", {31'h0, wr_if.o_wr_ack}, 32'h1);
        wr_if.i_wr_en = 1'b0;
        step();
        chk("blink_others", {8'h0, o_seg[31:8]}, 32'h0019_B0A4);
        for (int i = 0; i < 20; i++) begin
            blink_exp = ((((ecnt - 1) / 8) % 2) != 0) ? 8'hFF : 8'h80;
            chk("blink", {24'h0, o_seg[7:0]}, {24'h0, blink_exp});
            step();
        end

        // Reset in the middle of a write burst.
        wr_if.i_wr_en = 1'b1; wr_if.i_wr_addr = 2'd1; wr_if.i_wr_data = 8'h07;
        step();
        chk("rw_ack", {31'h0, wr_if.o_wr_ack}, 32'h1);
        rst_n = 1'b0;
        step();
        chk("rw_ack_drop", {30'h0, wr_if.o_wr_ack, wr_if.o_wr_err}, 32'h0);
        chk("rw_seg_off", o_seg, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        wr_if.i_wr_en = 1'b0;
        step();
        step();
        chk("rw_regs_blank", o_seg, 32'hFFFF_FFFF);
        chk("rw_mux_off", {20'h0, o_mux_an, o_mux_seg}, 32'h0000_0FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
